launch_scoreboard: RTL and testbench

Register scoreboard and issue-permission controller for the dual-issue launch stage. It tracks outstanding register writes from every issued instruction and gates line1/line2 issue against RAW, WAW and in-order pairing hazards. It sits beside the launch stage: candidate register usage comes in, per-line ready flags go out, and writeback retirement decrements the pending counts.

---
 rtl/launch_scoreboard.sv | 120 ++++++++++++
 tb/tb_launch_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/launch_scoreboard.sv
// Register scoreboard for the dual-issue launch stage: per-register pending-write
// counters, RAW/WAW/pairing issue gating, and a sticky protocol-error flag.
module launch_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              excep_flush_i,
    input  logic              line1_re1_i,
    input  logic              line1_re2_i,
    input  logic [ADDR_W-1:0] line1_raddr1_i,
    input  logic [ADDR_W-1:0] line1_raddr2_i,
    input  logic              line1_we_i,
    input  logic [ADDR_W-1:0] line1_waddr_i,
    input  logic              line1_issue_i,
    input  logic              line2_re1_i,
    input  logic              line2_re2_i,
    input  logic [ADDR_W-1:0] line2_raddr1_i,
    input  logic [ADDR_W-1:0] line2_raddr2_i,
    input  logic              line2_we_i,
    input  logic [ADDR_W-1:0] line2_waddr_i,
    input  logic              line2_issue_i,
    input  logic              wb1_valid_i,
    input  logic [ADDR_W-1:0] wb1_waddr_i,
    input  logic              wb2_valid_i,
    input  logic [ADDR_W-1:0] wb2_waddr_i,
    output logic              line1_ready_o,
    output logic              line2_ready_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int NW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_NUM-1:0] pend_vec, sat_vec, near_vec, err_vec, nz_next;
    logic               busy_reg, err_reg;
    logic               line2_ok, proto_err;

    // Register 0 is never tracked: all of its status bits are tied low.
    assign pend_vec[0] = 1'b0;
    assign sat_vec[0]  = 1'b0;
    assign near_vec[0] = 1'b0;
    assign err_vec[0]  = 1'b0;
    assign nz_next[0]  = 1'b0;

    // line2 only counts as issued when paired with line1.
    assign line2_ok  = line2_issue_i & line1_issue_i;
    assign proto_err = line2_issue_i & ~line1_issue_i;

    genvar gi;
    generate
        for (gi = 1; gi < REG_NUM; gi++) begin : g_reg
            logic [CNT_W-1:0]     cnt_reg, cnt_next;
            logic signed [NW-1:0] net;
            logic                 inc1, inc2, dec1, dec2, ovf, unf;

            assign inc1 = line1_issue_i & line1_we_i & (line1_waddr_i == ADDR_W'(gi));
            assign inc2 = line2_ok & line2_we_i & (line2_waddr_i == ADDR_W'(gi));
            assign dec1 = wb1_valid_i & (wb1_waddr_i == ADDR_W'(gi));
            assign dec2 = wb2_valid_i & (wb2_waddr_i == ADDR_W'(gi));

            always_comb begin
                net = $signed({2'b00, cnt_reg}) + $signed(NW'(inc1)) + $signed(NW'(inc2))
                    - $signed(NW'(dec1)) - $signed(NW'(dec2));
                unf      = net[NW-1];
                ovf      = !unf && (net > $signed({2'b00, CNT_MAX}));
                cnt_next = net[CNT_W-1:0];
                if (unf) cnt_next = '0;
                if (ovf) cnt_next = CNT_MAX;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)             cnt_reg <= '0;
                else if (excep_flush_i) cnt_reg <= '0;
                else                    cnt_reg <= cnt_next;
            end

            assign pend_vec[gi] = |cnt_reg;
            assign sat_vec[gi]  = (cnt_reg == CNT_MAX);
            // Set when two more writers would overflow the counter.
            assign near_vec[gi] = (cnt_reg >= CNT_MAX - 1'b1);
            assign err_vec[gi]  = ovf | unf;
            assign nz_next[gi]  = |cnt_next;
        end
    endgenerate

    always_comb begin
        line1_ready_o = !(line1_re1_i && pend_vec[line1_raddr1_i])
                     && !(line1_re2_i && pend_vec[line1_raddr2_i])
                     && !(line1_we_i  && sat_vec[line1_waddr_i]);
        line2_ready_o = line1_ready_o
                     && !(line2_re1_i && pend_vec[line2_raddr1_i])
                     && !(line2_re2_i && pend_vec[line2_raddr2_i])
                     && !(line2_we_i  && sat_vec[line2_waddr_i]);
        if (line1_we_i && line1_waddr_i != '0
            && ((line2_re1_i && line2_raddr1_i == line1_waddr_i)
             || (line2_re2_i && line2_raddr2_i == line1_waddr_i)))
            line2_ready_o = 1'b0;
        if (line1_we_i && line2_we_i && line1_waddr_i == line2_waddr_i
            && near_vec[line1_waddr_i])
            line2_ready_o = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else if (excep_flush_i) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= |nz_next;
            err_reg  <= err_reg | proto_err | (|err_vec);
        end
    end

    assign busy_o = busy_reg;
    assign err_o  = err_reg;
endmodule

// File: tb/tb_launch_scoreboard.sv
// Self-checking bench for launch_scoreboard: directed scenarios then random traffic
// against an integer-array reference model of the scoreboard rules.
module tb_launch_scoreboard;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic excep_flush_i;
    logic line1_re1_i, line1_re2_i, line1_we_i, line1_issue_i;
    logic line2_re1_i, line2_re2_i, line2_we_i, line2_issue_i;
    logic [4:0] line1_raddr1_i, line1_raddr2_i, line1_waddr_i;
    logic [4:0] line2_raddr1_i, line2_raddr2_i, line2_waddr_i;
    logic wb1_valid_i, wb2_valid_i;
    logic [4:0] wb1_waddr_i, wb2_waddr_i;
    logic line1_ready_o, line2_ready_o, busy_o, err_o;

    int total = 0;
    int bad = 0;
    int m_cnt [32];
    bit m_err;

    launch_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .excep_flush_i(excep_flush_i),
        .line1_re1_i(line1_re1_i), .line1_re2_i(line1_re2_i),
        .line1_raddr1_i(line1_raddr1_i), .line1_raddr2_i(line1_raddr2_i),
        .line1_we_i(line1_we_i), .line1_waddr_i(line1_waddr_i), .line1_issue_i(line1_issue_i),
        .line2_re1_i(line2_re1_i), .line2_re2_i(line2_re2_i),
        .line2_raddr1_i(line2_raddr1_i), .line2_raddr2_i(line2_raddr2_i),
        .line2_we_i(line2_we_i), .line2_waddr_i(line2_waddr_i), .line2_issue_i(line2_issue_i),
        .wb1_valid_i(wb1_valid_i), .wb1_waddr_i(wb1_waddr_i),
        .wb2_valid_i(wb2_valid_i), .wb2_waddr_i(wb2_waddr_i),
        .line1_ready_o(line1_ready_o), .line2_ready_o(line2_ready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic bit pend(input logic [4:0] a);
        return (a != 0) && (m_cnt[a] != 0);
    endfunction

    function automatic bit sat(input logic [4:0] a);
        return (a != 0) && (m_cnt[a] == MAXC);
    endfunction

    function automatic bit exp_ready1();
        return !(line1_re1_i && pend(line1_raddr1_i)) && !(line1_re2_i && pend(line1_raddr2_i))
            && !(line1_we_i && sat(line1_waddr_i));
    endfunction

    function automatic bit exp_ready2();
        bit raw, same;
        raw = line1_we_i && (line1_waddr_i != 0)
            && ((line2_re1_i && line2_raddr1_i == line1_waddr_i)
             || (line2_re2_i && line2_raddr2_i == line1_waddr_i));
        same = line1_we_i && line2_we_i && (line1_waddr_i == line2_waddr_i)
            && (line1_waddr_i != 0) && (m_cnt[line1_waddr_i] > MAXC - 2);
        return exp_ready1() && !(line2_re1_i && pend(line2_raddr1_i))
            && !(line2_re2_i && pend(line2_raddr2_i)) && !(line2_we_i && sat(line2_waddr_i))
            && !raw && !same;
    endfunction

    function automatic bit exp_busy();
        for (int a = 1; a < 32; a++) if (m_cnt[a] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference update: tally signed deltas per register, then clamp.
    task automatic model_step();
        int delta [32];
        if (excep_flush_i) begin
            for (int a = 0; a < 32; a++) m_cnt[a] = 0;
            return;
        end
        for (int a = 0; a < 32; a++) delta[a] = 0;
        if (line1_issue_i && line1_we_i) delta[line1_waddr_i]++;
        if (line2_issue_i && line1_issue_i && line2_we_i) delta[line2_waddr_i]++;
        if (line2_issue_i && !line1_issue_i) m_err = 1'b1;
        if (wb1_valid_i) delta[wb1_waddr_i]--;
        if (wb2_valid_i) delta[wb2_waddr_i]--;
        for (int a = 1; a < 32; a++) begin
            int v;
            v = m_cnt[a] + delta[a];
            if (v < 0) begin v = 0; m_err = 1'b1; end
            if (v > MAXC) begin v = MAXC; m_err = 1'b1; end
            m_cnt[a] = v;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic idle();
        excep_flush_i = 0;
        {line1_re1_i, line1_re2_i, line1_we_i, line1_issue_i} = '0;
        {line2_re1_i, line2_re2_i, line2_we_i, line2_issue_i} = '0;
        {line1_raddr1_i, line1_raddr2_i, line1_waddr_i} = '0;
        {line2_raddr1_i, line2_raddr2_i, line2_waddr_i} = '0;
        {wb1_valid_i, wb2_valid_i, wb1_waddr_i, wb2_waddr_i} = '0;
    endtask

    // Inputs are set just after a falling edge; ready is checked mid-cycle,
    // busy/err just after the rising edge.
    task automatic do_cycle(input string tag);
        bit e1, e2;
        e1 = exp_ready1();
        e2 = exp_ready2();
        #1;
        chk({tag, ".ready1"}, line1_ready_o, e1);
        chk({tag, ".ready2"}, line2_ready_o, e2);
        @(posedge clk);
        model_step();
        #1;
        chk({tag, ".busy"}, busy_o, exp_busy());
        chk({tag, ".err"}, err_o, m_err);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        for (int a = 0; a < 32; a++) m_cnt[a] = 0;
        m_err = 0;
        #1;
        chk("reset.busy", busy_o, 1'b0);
        chk("reset.err", err_o, 1'b0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        for (int a = 0; a < 32; a++) m_cnt[a] = 0;
        m_err = 0;
        do_reset();
        do_cycle("idle");

        line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 5;
        do_cycle("issue_r5");
        idle(); line1_re1_i = 1; line1_raddr1_i = 5;
        do_cycle("read_r5_pending");
        do_cycle("read_r5_wait");
        idle(); wb1_valid_i = 1; wb1_waddr_i = 5;
        do_cycle("wb_r5");
        idle(); line1_re1_i = 1; line1_raddr1_i = 5;
        do_cycle("read_r5_woken");

        idle(); line1_we_i = 1; line1_waddr_i = 3; line2_re1_i = 1; line2_raddr1_i = 3;
        do_cycle("pair_raw_r3");
        line1_waddr_i = 0;
        do_cycle("pair_raw_r0");
        idle(); line1_we_i = 1; line1_waddr_i = 3; line2_re2_i = 1; line2_raddr2_i = 3;
        do_cycle("pair_raw_re2");

        for (int i = 0; i < 3; i++) begin
            idle(); line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 7;
            do_cycle("issue_r7");
        end
        idle(); line1_we_i = 1; line1_waddr_i = 7;
        do_cycle("r7_sat");
        idle(); wb1_valid_i = 1; wb1_waddr_i = 7;
        do_cycle("wb_r7");
        idle(); line1_we_i = 1; line1_waddr_i = 7; line2_we_i = 1; line2_waddr_i = 7;
        do_cycle("pair_r7_cnt2");
        idle(); wb1_valid_i = 1; wb1_waddr_i = 7; wb2_valid_i = 1; wb2_waddr_i = 7;
        do_cycle("wb2_r7");

        idle(); line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 4;
        line2_issue_i = 1; line2_we_i = 1; line2_waddr_i = 6;
        do_cycle("issue_r4_r6");
        idle(); excep_flush_i = 1; line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 8;
        wb1_valid_i = 1; wb1_waddr_i = 9;
        do_cycle("flush");
        idle(); line1_re1_i = 1; line1_raddr1_i = 8; line2_re1_i = 1; line2_raddr1_i = 4;
        do_cycle("after_flush");
        idle(); line2_issue_i = 1; line2_we_i = 1; line2_waddr_i = 10;
        do_cycle("line2_alone");
        idle(); line1_re1_i = 1; line1_raddr1_i = 10;
        do_cycle("line2_alone_dropped");

        do_reset();
        idle(); line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 9;
        do_cycle("issue_r9");
        wb1_valid_i = 1; wb1_waddr_i = 9;
        do_cycle("issue_wb_r9");
        idle(); line1_issue_i = 1; line1_we_i = 1; line1_waddr_i = 9;
        do_cycle("issue_r9_b");
        idle(); wb1_valid_i = 1; wb1_waddr_i = 9; wb2_valid_i = 1; wb2_waddr_i = 9;
        do_cycle("wb2_r9");
        idle(); wb1_valid_i = 1; wb1_waddr_i = 0;
        do_cycle("wb_r0");
        wb1_waddr_i = 9;
        do_cycle("wb_r9_underflow");
        idle(); line1_re1_i = 1; line1_raddr1_i = 9;
        do_cycle("r9_clamped");

        do_reset();
        for (int i = 0; i < 400; i++) begin
            idle();
            line1_re1_i = 1'($urandom); line1_raddr1_i = 5'($urandom_range(0, 7));
            line1_re2_i = 1'($urandom); line1_raddr2_i = 5'($urandom_range(0, 7));
            line1_we_i  = 1'($urandom); line1_waddr_i  = 5'($urandom_range(0, 7));
            line2_re1_i = 1'($urandom); line2_raddr1_i = 5'($urandom_range(0, 7));
            line2_re2_i = 1'($urandom); line2_raddr2_i = 5'($urandom_range(0, 7));
            line2_we_i  = 1'($urandom); line2_waddr_i  = 5'($urandom_range(0, 7));
            line1_issue_i = ($urandom_range(0, 2) == 0);
            line2_issue_i = line1_issue_i ? 1'($urandom) : ($urandom_range(0, 40) == 0);
            wb1_valid_i = ($urandom_range(0, 2) == 0); wb1_waddr_i = 5'($urandom_range(0, 7));
            wb2_valid_i = ($urandom_range(0, 3) == 0); wb2_waddr_i = 5'($urandom_range(0, 7));
            excep_flush_i = ($urandom_range(0, 50) == 0);
            do_cycle("rand");
            if (i % 100 == 99) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
